bin_down_counter: RTL and testbench

BIN_DOWN_COUNTER -- requirements
Module: bin_down_counter

---
 rtl/bin_cnt_pkg.sv | 13 +
 rtl/down_cnt_cell.sv | 27 ++
 rtl/bin_down_counter.sv | 104 ++++++++++
 tb/tb_bin_down_counter.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/bin_cnt_pkg.sv
// Shared definitions for the binary down-counter: state encoding and defaults.
package bin_cnt_pkg;

  // Default counter width when the parent does not override WIDTH.
  localparam int CNT_WIDTH_DFLT = 4;

  // RUN: counting (or waiting for en). HOLD: one-shot finished at zero.
  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HOLD = 1'b1
  } cnt_state_e;

endpackage

// File: rtl/down_cnt_cell.sv
// One bit of the down-counter: synchronous toggle flop with parallel load.
// Priority inside the cell is rst, then ld, then tog.
module down_cnt_cell (
  input  logic clk,
  input  logic rst,
  input  logic tog,
  input  logic ld,
  input  logic d,
  output logic q
);

  logic q_q;

  // Bit storage: clear, load, or toggle on the rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= 1'b0;
    end else if (ld) begin
      q_q <= d;
    end else if (tog) begin
      q_q <= ~q_q;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/bin_down_counter.sv
// Binary down-counter built from per-bit toggle cells, with a reload
// register, optional auto-reload on underflow and a registered borrow pulse.
module bin_down_counter
  import bin_cnt_pkg::*;
#(
  parameter int WIDTH       = CNT_WIDTH_DFLT,
  parameter int AUTO_RELOAD = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             zero,
  output logic             borrow,
  output logic             busy
);

  localparam logic AUTO_RELOAD_BIT = (AUTO_RELOAD != 0);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] reload_q;
  logic [WIDTH-1:0] reload_d;
  cnt_state_e       state_q;
  cnt_state_e       state_d;
  logic             borrow_q;
  logic             borrow_d;

  logic             cnt_is_zero;
  logic             run_en;
  logic             underflow;
  logic             dec;
  logic             cell_ld;
  logic [WIDTH-1:0] cell_d;
  logic [WIDTH-1:0] lower_zero;

  // load wins over en, and HOLD ignores en entirely.
  assign cnt_is_zero = (cnt_q == '0);
  assign run_en      = en & (state_q == RUN) & ~load;
  assign underflow   = run_en & cnt_is_zero;
  assign dec         = run_en & ~cnt_is_zero;

  // Cells load either the external value or, on auto-reload underflow, the
  // reload register. In one-shot mode an underflow leaves the cells at zero.
  assign cell_ld = load | (underflow & AUTO_RELOAD_BIT);
  assign cell_d  = load ? load_val : reload_q;

  // A bit toggles on a decrement only when every bit below it is zero.
  assign lower_zero[0] = 1'b1;
  generate
    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_lz
      assign lower_zero[gi] = lower_zero[gi-1] & ~cnt_q[gi-1];
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      down_cnt_cell u_cell (
        .clk (clk),
        .rst (rst),
        .tog (dec & lower_zero[gi]),
        .ld  (cell_ld),
        .d   (cell_d[gi]),
        .q   (cnt_q[gi])
      );
    end
  endgenerate

  // Next-state for the reload register, state machine and borrow pulse.
  always_comb begin
    reload_d = reload_q;
    state_d  = state_q;
    borrow_d = 1'b0;
    if (load) begin
      reload_d = load_val;
      state_d  = RUN;
    end else if (underflow) begin
      borrow_d = 1'b1;
      if (!AUTO_RELOAD_BIT) begin
        state_d = HOLD;
      end
    end
  end

  // Control registers; reset leaves the reload register at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      reload_q <= '1;
      state_q  <= RUN;
      borrow_q <= 1'b0;
    end else begin
      reload_q <= reload_d;
      state_q  <= state_d;
      borrow_q <= borrow_d;
    end
  end

  assign q      = cnt_q;
  assign zero   = cnt_is_zero;
  assign borrow = borrow_q;
  assign busy   = (state_q == RUN);

endmodule

// File: tb/tb_bin_down_counter.sv
// Directed bench for bin_down_counter: an auto-reload and a one-shot instance
// share the same stimulus; each check targets the instance under test.
module tb_bin_down_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;

  logic [3:0] ar_q;
  logic       ar_zero, ar_borrow, ar_busy;
  logic [3:0] os_q;
  logic       os_zero, os_borrow, os_busy;

  int total_cnt = 0;
  int bad_cnt   = 0;

  always #5 clk = ~clk;

  bin_down_counter #(.WIDTH(4), .AUTO_RELOAD(1)) dut_ar (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .q        (ar_q),
    .zero     (ar_zero),
    .borrow   (ar_borrow),
    .busy     (ar_busy)
  );

  bin_down_counter #(.WIDTH(4), .AUTO_RELOAD(0)) dut_os (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .q        (os_q),
    .zero     (os_zero),
    .borrow   (os_borrow),
    .busy     (os_busy)
  );

  task automatic chk(input string tag, input int got, input int exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Check the auto-reload instance: q, borrow, zero.
  task automatic chk_ar(input string tag, input int exp_q, input int exp_b);
    $display("t=%0t %s ar q=%0d borrow=%0b zero=%0b busy=%0b",
             $time, tag, ar_q, ar_borrow, ar_zero, ar_busy);
    chk({tag, ".q"}, ar_q, exp_q);
    chk({tag, ".borrow"}, ar_borrow, exp_b);
    chk({tag, ".zero"}, ar_zero, (exp_q == 0) ? 1 : 0);
  endtask

  // Check the one-shot instance: q, borrow, busy, zero.
  task automatic chk_os(input string tag, input int exp_q, input int exp_b, input int exp_busy);
    $display("t=%0t %s os q=%0d borrow=%0b zero=%0b busy=%0b",
             $time, tag, os_q, os_borrow, os_zero, os_busy);
    chk({tag, ".q"}, os_q, exp_q);
    chk({tag, ".borrow"}, os_borrow, exp_b);
    chk({tag, ".busy"}, os_busy, exp_busy);
    chk({tag, ".zero"}, os_zero, (exp_q == 0) ? 1 : 0);
  endtask

  initial begin
    int exp_seq[5];

    // Reset state.
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_ar("reset", 0, 0);
    chk("reset.busy", ar_busy, 1);

    // From reset, first enabled edge underflows to the all-ones reload value.
    en = 1'b1;
    step(); chk_ar("run0", 15, 1);
    step(); chk_ar("run1", 14, 0);
    step(); chk_ar("run2", 13, 0);

    // Load 3, then count through an auto-reload.
    en = 1'b0; load = 1'b1; load_val = 4'd3;
    step(); chk_ar("ld3", 3, 0);
    load = 1'b0; en = 1'b1;
    exp_seq = '{2, 1, 0, 3, 2};
    for (int i = 0; i < 5; i++) begin
      step();
      chk_ar($sformatf("ld3.cnt%0d", i), exp_seq[i], (i == 3) ? 1 : 0);
    end

    // Reach zero, then load with en on an underflow edge: borrow suppressed.
    step(); chk_ar("to1", 1, 0);
    step(); chk_ar("to0", 0, 0);
    load = 1'b1; load_val = 4'd9;
    step(); chk_ar("ld_vs_uf", 9, 0);

    // Load 6 and idle for 8 cycles.
    load_val = 4'd6;
    step(); chk_ar("ld6", 6, 0);
    load = 1'b0; en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk_ar($sformatf("idle%0d", i), 6, 0);
    end

    // load_val 0: next enabled edge underflows and reloads 0.
    load = 1'b1; load_val = 4'd0;
    step(); chk_ar("ld0", 0, 0);
    load = 1'b0; en = 1'b1;
    step(); chk_ar("ld0.uf", 0, 1);
    step(); chk_ar("ld0.uf2", 0, 1);

    // Reset overrides load and en at q=5; reload register returns to 15.
    en = 1'b0; load = 1'b1; load_val = 4'd5;
    step(); chk_ar("ld5", 5, 0);
    rst = 1'b1; load = 1'b1; en = 1'b1; load_val = 4'd7;
    step(); chk_ar("rst_mid", 0, 0);
    chk("rst_mid.busy", ar_busy, 1);
    rst = 1'b0; load = 1'b0; en = 1'b1;
    step(); chk_ar("rst_mid.uf", 15, 1);

    // One-shot instance: load 2, run down, stop in HOLD.
    en = 1'b0; load = 1'b1; load_val = 4'd2;
    step(); chk_os("os.ld2", 2, 0, 1);
    load = 1'b0; en = 1'b1;
    step(); chk_os("os.c1", 1, 0, 1);
    step(); chk_os("os.c0", 0, 0, 1);
    step(); chk_os("os.uf", 0, 1, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk_os($sformatf("os.hold%0d", i), 0, 0, 0);
    end
    // Only load leaves HOLD.
    load = 1'b1; load_val = 4'd4;
    step(); chk_os("os.reld", 4, 0, 1);
    load = 1'b0;
    step(); chk_os("os.rerun", 3, 0, 1);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
